// File: rtl/msdap_pot_mac_engine.sv
// Power-of-two coefficient MAC engine for the MSDAP filter.
// For each accepted sample the engine walks CH channels in turn. Each channel
// has NUM_U groups, and every group j holds r_j signed taps. The partial sums
// are weighted by 2^-(NUM_U-j) by applying one arithmetic right shift after
// every group. The rj-count, coefficient and sample memories sit outside the
// block and have a one-cycle read latency.
module msdap_pot_mac_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 16,
  parameter int ACC_W   = 40,
  parameter int NUM_U   = 16,
  parameter int RJ_W    = 8,
  parameter int COEF_AW = 9,
  parameter int X_AW    = 8,
  parameter int CH      = 2,
  localparam int UW     = $clog2(NUM_U),
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     sClk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     sleep,
  input  logic                     sat_en,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [X_AW-1:0]          n,
  input  logic                     x_wrapped,
  output logic                     rj_rd_en,
  output logic [CHW+UW-1:0]        rj_addr,
  input  logic [RJ_W-1:0]          rj_data,
  output logic                     h_rd_en,
  output logic [CHW+COEF_AW-1:0]   h_addr,
  input  logic [15:0]              h_data,
  output logic                     x_rd_en,
  output logic [CHW+X_AW-1:0]      x_addr,
  input  logic [DATA_W-1:0]        x_data,
  output logic [ACC_W-1:0]         y,
  output logic [CHW-1:0]           y_ch,
  output logic                     y_valid,
  output logic                     coef_err
);

  // hptr carries one extra bit so that "table exhausted" (hptr == H_DEPTH)
  // can be seen without wrapping back to entry 0.
  localparam int HPW = COEF_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RJ_RD  = 3'd1,
    S_RJ_LAT = 3'd2,
    S_H_RD   = 3'd3,
    S_H_LAT  = 3'd4,
    S_X_LAT  = 3'd5,
    S_SHIFT  = 3'd6,
    S_OUT    = 3'd7
  } state_t;

  state_t            state_q;
  logic [X_AW-1:0]   n_q;
  logic              wrapped_q;
  logic [CHW-1:0]    ch_q;
  logic [UW-1:0]     j_q;
  logic [HPW-1:0]    hptr_q;
  logic [RJ_W-1:0]   rj_q;
  logic [RJ_W-1:0]   cnt_q;
  logic              sign_q;
  logic              skip_q;
  logic [ACC_W-1:0]  u_q;
  logic [ACC_W-1:0]  y_q;
  logic [CHW-1:0]    y_ch_q;
  logic              y_valid_q;
  logic              coef_err_q;
  logic              rj_rd_en_q;
  logic              h_rd_en_q;

  logic [X_AW:0]     idx_d;
  logic              skip_d;
  logic [ACC_W-1:0]  xa_d;
  logic [ACC_W-1:0]  u_acc_d;
  logic [ACC_W-1:0]  u_shift_d;
  logic [HPW-1:0]    hptr_inc_d;
  logic [RJ_W-1:0]   cnt_inc_d;
  logic              last_j_d;
  logic              last_ch_d;

  // Sign-extend a sample to accumulator width and place it FRAC_W bits up.
  function automatic logic [ACC_W-1:0] align_x(input logic [DATA_W-1:0] x);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    return ext << FRAC_W;
  endfunction

  // Add or subtract with one guard bit. Overflow is either clamped or left to
  // wrap in two's complement.
  function automatic logic [ACC_W-1:0] mac_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b,
                                                input logic             sub,
                                                input logic             sat);
    logic [ACC_W:0]   s;
    logic [ACC_W-1:0] res;
    if (sub) begin
      s = {a[ACC_W-1], a} - {b[ACC_W-1], b};
    end else begin
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    end
    if (sat && (s[ACC_W] != s[ACC_W-1])) begin
      res = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      res = s[ACC_W-1:0];
    end
    return res;
  endfunction

  // Sample index n-k. A borrow before the history has filled means the tap
  // refers to a sample that does not exist yet, so it contributes zero.
  assign idx_d      = {1'b0, n_q} - {1'b0, h_data[X_AW-1:0]};
  assign skip_d     = idx_d[X_AW] & ~wrapped_q;
  assign xa_d       = skip_q ? {ACC_W{1'b0}} : align_x(x_data);
  assign u_acc_d    = mac_add(u_q, xa_d, sign_q, sat_en);
  assign u_shift_d  = {u_q[ACC_W-1], u_q[ACC_W-1:1]};
  assign hptr_inc_d = hptr_q + HPW'(1);
  assign cnt_inc_d  = cnt_q + RJ_W'(1);
  assign last_j_d   = (j_q == UW'(NUM_U - 1));
  assign last_ch_d  = (ch_q == CHW'(CH - 1));

  // The sample read has to be issued in the same cycle the coefficient arrives,
  // so that x_data is ready in X_LAT. For this reason it is decoded from the
  // registered state and the returned tap.
  assign x_rd_en      = (state_q == S_H_LAT) && !skip_d;
  assign x_addr       = (state_q == S_H_LAT) ? {ch_q, idx_d[X_AW-1:0]} : {(CHW+X_AW){1'b0}};
  assign sample_ready = (state_q == S_IDLE) && !sleep;
  assign rj_rd_en     = rj_rd_en_q;
  assign rj_addr      = {ch_q, j_q};
  assign h_rd_en      = h_rd_en_q;
  assign h_addr       = {ch_q, hptr_q[COEF_AW-1:0]};
  assign y            = y_q;
  assign y_ch         = y_ch_q;
  assign y_valid      = y_valid_q;
  assign coef_err     = coef_err_q;

  // Sequencer: channel/group/tap walk, accumulation and result registers.
  always_ff @(posedge sClk) begin
    if (!reset || start) begin
      // reset dominates start; both return the engine to an idle, cleared state
      state_q    <= S_IDLE;
      n_q        <= {X_AW{1'b0}};
      wrapped_q  <= 1'b0;
      ch_q       <= {CHW{1'b0}};
      j_q        <= {UW{1'b0}};
      hptr_q     <= {HPW{1'b0}};
      rj_q       <= {RJ_W{1'b0}};
      cnt_q      <= {RJ_W{1'b0}};
      sign_q     <= 1'b0;
      skip_q     <= 1'b0;
      u_q        <= {ACC_W{1'b0}};
      y_q        <= {ACC_W{1'b0}};
      y_ch_q     <= {CHW{1'b0}};
      y_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;
      rj_rd_en_q <= 1'b0;
      h_rd_en_q  <= 1'b0;
    end else begin
      rj_rd_en_q <= 1'b0;
      h_rd_en_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sample_valid && sample_ready) begin
            n_q        <= n;
            wrapped_q  <= x_wrapped;
            ch_q       <= {CHW{1'b0}};
            j_q        <= {UW{1'b0}};
            hptr_q     <= {HPW{1'b0}};
            u_q        <= {ACC_W{1'b0}};
            rj_rd_en_q <= 1'b1;
            state_q    <= S_RJ_RD;
          end
        end
        S_RJ_RD: begin
          state_q <= S_RJ_LAT;
        end
        S_RJ_LAT: begin
          rj_q  <= rj_data;
          cnt_q <= {RJ_W{1'b0}};
          if (rj_data == {RJ_W{1'b0}}) begin
            state_q <= S_SHIFT;
          end else if (hptr_q[COEF_AW]) begin
            coef_err_q <= 1'b1;
            state_q    <= S_SHIFT;
          end else begin
            h_rd_en_q <= 1'b1;
            state_q   <= S_H_RD;
          end
        end
        S_H_RD: begin
          state_q <= S_H_LAT;
        end
        S_H_LAT: begin
          sign_q  <= h_data[8];
          skip_q  <= skip_d;
          state_q <= S_X_LAT;
        end
        S_X_LAT: begin
          u_q    <= u_acc_d;
          hptr_q <= hptr_inc_d;
          cnt_q  <= cnt_inc_d;
          if (cnt_inc_d == rj_q) begin
            state_q <= S_SHIFT;
          end else if (hptr_inc_d[COEF_AW]) begin
            coef_err_q <= 1'b1;
            state_q    <= S_SHIFT;
          end else begin
            h_rd_en_q <= 1'b1;
            state_q   <= S_H_RD;
          end
        end
        S_SHIFT: begin
          u_q <= u_shift_d;
          if (last_j_d) begin
            y_q       <= u_shift_d;
            y_ch_q    <= ch_q;
            y_valid_q <= 1'b1;
            state_q   <= S_OUT;
          end else begin
            j_q        <= j_q + UW'(1);
            rj_rd_en_q <= 1'b1;
            state_q    <= S_RJ_RD;
          end
        end
        S_OUT: begin
          if (last_ch_d) begin
            state_q <= S_IDLE;
          end else begin
            ch_q       <= ch_q + CHW'(1);
            u_q        <= {ACC_W{1'b0}};
            hptr_q     <= {HPW{1'b0}};
            j_q        <= {UW{1'b0}};
            rj_rd_en_q <= 1'b1;
            state_q    <= S_RJ_RD;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
